fft_stage_sequencer: RTL and testbench

- Sequences one radix-2, in-place, decimation-in-frequency FFT over N = 2^LOG2N points.
- Drives the shared dual-read sample RAM, the twiddle ROM and the pipelined butterfly unit.
- For each stage it issues N/2 butterfly read/compute operations back-to-back, then steers the butterfly results back to their source addresses.
- Before starting the next stage it drains the pipeline, so there is no read-after-write hazard between stages.

---
 rtl/fft_stage_sequencer.sv | 95 +++++++++
 tb/tb_fft_stage_sequencer.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/fft_stage_sequencer.sv
// fft_stage_sequencer: radix-2 in-place DIF FFT read/twiddle/write-back sequencer with tag FIFO
module fft_stage_sequencer #(
  parameter int LOG2N = 6,
  parameter int ADDR_W = LOG2N,
  parameter int TAG_DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] stage_idx,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr_a,
  output logic [ADDR_W-1:0] rd_addr_b,
  output logic [ADDR_W-2:0] tw_addr,
  output logic              bf_valid_in,
  input  logic              bf_valid_out,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr_a,
  output logic [ADDR_W-1:0] wr_addr_b,
  output logic              err
);
  localparam int KW = ADDR_W - 1;
  localparam int PW = $clog2(TAG_DEPTH);
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FINISH} state_t;
  state_t state_q, state_d;
  logic [ADDR_W-1:0] stage_q, stage_d;
  logic [KW-1:0] k_q, k_d;
  logic bfv_q, err_q, err_d;
  logic [PW-1:0] wp_q, rp_q;
  logic [PW:0] cnt_q, cnt_d;
  logic [2*ADDR_W-1:0] tags [TAG_DEPTH];
  logic [ADDR_W-1:0] sh, span, kk, pos, addr_a;
  logic empty, full, push, pop, last_k, last_stage, drained;
  assign sh = ADDR_W'(LOG2N - 1) - stage_q;
  assign span = ADDR_W'(1) << sh;
  assign kk = {1'b0, k_q};
  assign pos = kk & (span - 1'b1);
  assign addr_a = ((kk >> sh) << (sh + 1'b1)) + pos;
  assign empty = cnt_q == '0;
  assign full = cnt_q == (PW+1)'(TAG_DEPTH);
  assign pop = bf_valid_out && !empty;
  assign push = rd_en && (!full || pop);
  assign last_k = k_q == '1;
  assign last_stage = stage_q == ADDR_W'(LOG2N - 1);
  assign drained = empty && !bf_valid_out;
  assign cnt_d = cnt_q + (PW+1)'(push) - (PW+1)'(pop);
  assign err_d = err_q || (bf_valid_out && empty) || (rd_en && full && !pop);
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      stage_q <= '0;
      k_q <= '0;
      bfv_q <= 1'b0;
      err_q <= 1'b0;
      wp_q <= '0;
      rp_q <= '0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      stage_q <= stage_d;
      k_q <= k_d;
      bfv_q <= rd_en;
      err_q <= err_d;
      wp_q <= wp_q + PW'(push);
      rp_q <= rp_q + PW'(pop);
      cnt_q <= cnt_d;
    end
  end
  always_ff @(posedge clk) if (push) tags[wp_q] <= {addr_a, addr_a | span};
  always_comb begin
    state_d = state_q == IDLE  ? (start ? ISSUE : IDLE)
            : state_q == ISSUE ? (last_k ? DRAIN : ISSUE)
            : state_q == DRAIN ? (drained ? (last_stage ? FINISH : ISSUE) : DRAIN)
            : IDLE;
    stage_d = state_q == IDLE ? '0
            : (state_q == DRAIN && drained && !last_stage) ? stage_q + 1'b1
            : stage_q;
    k_d = state_q == ISSUE ? k_q + 1'b1 : '0;
  end
  always_comb begin
    rd_en = state_q == ISSUE;
    busy = state_q == ISSUE || state_q == DRAIN;
    done = state_q == FINISH;
    rd_addr_a = rd_en ? addr_a : '0;
    rd_addr_b = rd_en ? (addr_a | span) : '0;
    tw_addr = rd_en ? KW'(pos << stage_q) : '0;
    {wr_addr_a, wr_addr_b} = pop ? tags[rp_q] : '0;
  end
  assign stage_idx = stage_q;
  assign bf_valid_in = bfv_q;
  assign wr_en = bf_valid_out;
  assign err = err_q;
endmodule

// File: tb/tb_fft_stage_sequencer.sv
// tb_fft_stage_sequencer: scoreboard bench for 8-point sequencing plus 64-point impulse transform
module tb_fft_stage_sequencer;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst = 1'b1, start = 1'b0, spur = 1'b0;
  logic busy, done, rd_en, bf_valid_in, bf_valid_out, wr_en, err;
  logic [2:0] stage_idx, rd_addr_a, rd_addr_b, wr_addr_a, wr_addr_b;
  logic [1:0] tw_addr;
  logic [1:0] pipe = 2'b0;
  assign bf_valid_out = pipe[1] | spur;
  always @(posedge clk) pipe <= {pipe[0], bf_valid_in};
  fft_stage_sequencer #(.LOG2N(3), .ADDR_W(3), .TAG_DEPTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .stage_idx(stage_idx),
    .rd_en(rd_en), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .tw_addr(tw_addr),
    .bf_valid_in(bf_valid_in), .bf_valid_out(bf_valid_out), .wr_en(wr_en),
    .wr_addr_a(wr_addr_a), .wr_addr_b(wr_addr_b), .err(err)
  );
  logic start6 = 1'b0, init6 = 1'b0, v1 = 1'b0, v2 = 1'b0;
  logic busy6, done6, rd6, bvi6, wr6, err6;
  logic [5:0] stage6, ra6, rb6, wa6, wb6;
  logic [4:0] tw6;
  int ram [64];
  int da, db, p1x, p1y, p2x, p2y;
  int rd6_cnt = 0;
  always @(posedge clk) begin
    if (init6) for (int i = 0; i < 64; i++) ram[i] <= (i == 0) ? 1 : 0;
    else if (wr6) begin
      ram[wa6] <= p2x;
      ram[wb6] <= p2y;
    end
    if (rd6) begin
      da <= ram[ra6];
      db <= ram[rb6];
      rd6_cnt <= rd6_cnt + 1;
    end
    p1x <= da + db;
    p1y <= da - db;
    v1 <= bvi6;
    p2x <= p1x;
    p2y <= p1y;
    v2 <= v1;
  end
  fft_stage_sequencer #(.LOG2N(6), .ADDR_W(6), .TAG_DEPTH(8)) dut6 (
    .clk(clk), .rst(rst), .start(start6), .busy(busy6), .done(done6), .stage_idx(stage6),
    .rd_en(rd6), .rd_addr_a(ra6), .rd_addr_b(rb6), .tw_addr(tw6),
    .bf_valid_in(bvi6), .bf_valid_out(v2), .wr_en(wr6),
    .wr_addr_a(wa6), .wr_addr_b(wb6), .err(err6)
  );
  typedef struct { int a; int b; int tw; int st; } rd_t;
  typedef struct { int a; int b; int cyc; } wb_t;
  rd_t rdq [$];
  wb_t wbq [$];
  rd_t r;
  wb_t w;
  int vectors = 0, miscompares = 0, cyc = 0, last_st = 0;
  bit mon_en = 1'b0;
  int exp_a [12] = '{0, 1, 2, 3, 0, 1, 4, 5, 0, 2, 4, 6};
  int exp_b [12] = '{4, 5, 6, 7, 2, 3, 6, 7, 1, 3, 5, 7};
  int exp_tw [12] = '{0, 1, 2, 3, 0, 2, 0, 2, 0, 0, 0, 0};
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  always @(negedge clk) if (mon_en) begin
    if (wr_en) begin
      if (wbq.size() == 0) chk("stray_wr", 1, 0);
      else begin
        w = wbq.pop_front();
        chk("wr_addr_a", wr_addr_a, w.a);
        chk("wr_addr_b", wr_addr_b, w.b);
        chk("wr_latency", cyc - w.cyc, 3);
      end
    end
    if (rd_en) begin
      if (rdq.size() == 0) chk("extra_rd", 1, 0);
      else begin
        r = rdq.pop_front();
        chk("rd_addr_a", rd_addr_a, r.a);
        chk("rd_addr_b", rd_addr_b, r.b);
        chk("tw_addr", tw_addr, r.tw);
        chk("stage_idx", stage_idx, r.st);
      end
      if (stage_idx != last_st) chk("stage_hazard", wbq.size(), 0);
      wbq.push_back('{rd_addr_a, rd_addr_b, cyc});
      last_st = stage_idx;
    end
  end
  task automatic tick;
    @(posedge clk);
    #2;
  endtask
  task automatic load_exp;
    for (int i = 0; i < 12; i++) rdq.push_back('{exp_a[i], exp_b[i], exp_tw[i], i / 4});
  endtask
  task automatic run(input bit mid);
    int n, dc;
    bit seen;
    load_exp();
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    dc = 0;
    seen = 1'b0;
    while (!seen && n < 200) begin
      if (done) begin
        seen = 1'b1;
        dc++;
        chk("busy_at_done", busy, 0);
      end else chk("busy_high", busy, 1);
      start = mid && n == 6;
      tick();
      n++;
    end
    start = 1'b0;
    if (!seen) chk("done_timeout", 0, 1);
    repeat (20) begin
      if (done) dc++;
      tick();
    end
    chk("done_count", dc, 1);
    chk("rd_left", rdq.size(), 0);
    chk("wb_left", wbq.size(), 0);
  endtask
  initial begin
    int n, bad;
    repeat (3) tick();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_rd_en", rd_en, 0);
    chk("rst_bf_valid_in", bf_valid_in, 0);
    chk("rst_err", err, 0);
    chk("rst_rd_addr_a", rd_addr_a, 0);
    chk("rst_rd_addr_b", rd_addr_b, 0);
    chk("rst_tw_addr", tw_addr, 0);
    chk("rst_stage_idx", stage_idx, 0);
    chk("rst_busy6", busy6, 0);
    rst = 1'b0;
    tick();
    init6 = 1'b1;
    tick();
    init6 = 1'b0;
    start6 = 1'b1;
    tick();
    start6 = 1'b0;
    n = 0;
    while (!done6 && n < 3000) begin
      tick();
      n++;
    end
    chk("done6_seen", done6, 1);
    bad = 0;
    for (int i = 0; i < 64; i++) if (ram[i] != 1) bad++;
    chk("impulse_bins_bad", bad, 0);
    chk("rd_cycles_64pt", rd6_cnt, 192);
    chk("err6", err6, 0);
    mon_en = 1'b1;
    run(1'b0);
    chk("err_after_run", err, 0);
    run(1'b1);
    load_exp();
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (!(rd_en && stage_idx == 3'd1 && rd_addr_a == 3'd4) && n < 100) begin
      tick();
      n++;
    end
    chk("reach_stage1", n < 100, 1);
    mon_en = 1'b0;
    rst = 1'b1;
    rdq.delete();
    wbq.delete();
    tick();
    rst = 1'b0;
    chk("midrst_busy", busy, 0);
    chk("midrst_rd_en", rd_en, 0);
    chk("midrst_fifo_empty", dut.cnt_q, 0);
    chk("midrst_err", err, 0);
    repeat (4) tick();
    chk("late_valid_err", err, 1);
    mon_en = 1'b1;
    last_st = 0;
    run(1'b0);
    chk("err_sticky_run", err, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("err_cleared", err, 0);
    mon_en = 1'b0;
    spur = 1'b1;
    #1;
    chk("spur_wr_en", wr_en, 1);
    tick();
    spur = 1'b0;
    chk("spur_err", err, 1);
    chk("spur_no_pop", dut.cnt_q, 0);
    mon_en = 1'b1;
    last_st = 0;
    run(1'b0);
    chk("spur_err_sticky", err, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("spur_err_cleared", err, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
  initial begin
    #1000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end
endmodule
